// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the program-counter sequencing controller:
// decoded op kinds, pc modes and the controller state type.
package pc_ctrl_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BR   = 3'd2;
    localparam logic [2:0] OP_HALT = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    // Hold is deliberately its own code so the pc can tell "keep value" apart from a step.
    localparam logic [2:0] PC_MODE_NORMAL = 3'd0;
    localparam logic [2:0] PC_MODE_ADD    = 3'd1;
    localparam logic [2:0] PC_MODE_JUMP   = 3'd2;
    localparam logic [2:0] PC_MODE_HOLD   = 3'd3;

    typedef enum logic [2:0] {
        CTRL_BOOT   = 3'd0,
        CTRL_FETCH  = 3'd1,
        CTRL_EXEC   = 3'd2,
        CTRL_HALT   = 3'd3,
        CTRL_RESUME = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/pc_ctrl_ret_stack.sv
// ret_stack: small LIFO of return addresses for call/ret; dout shows the
// top entry combinationally so a ret can jump in the same cycle it pops.
module ret_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [AW-1:0]    top_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = AW'(count - CW'(1));
    assign dout    = mem[top_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // Entries need no reset: an entry is only ever read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch/execute sequencer driving the pc's reset, mode and offset.
// Define PC_CALL_STACK_EN to add call/ret through a return-address stack.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_ready,
    input  logic [2:0]       op_kind,
    input  logic [WIDTH-1:0] op_target,
    input  logic             cond_flag,
    input  logic             resume,
    input  logic [WIDTH-1:0] pc_value,
    output logic             pc_reset,
    output logic [2:0]       pc_mode,
    output logic [WIDTH-1:0] pc_offset,
    output logic             fetch_req,
    output logic             halted,
    output logic             stack_err
);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    logic [2:0]       op_kind_q;
    logic [WIDTH-1:0] op_target_q;

`ifdef PC_CALL_STACK_EN
    logic             push;
    logic             pop;
    logic             stk_full;
    logic             stk_empty;
    logic [WIDTH-1:0] stk_dout;
    logic [WIDTH-1:0] ret_addr;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CTRL_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // The op is captured on the FETCH edge so EXEC decodes a stable copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_kind_q   <= OP_NOP;
            op_target_q <= '0;
        end else if (state == CTRL_FETCH && mem_ready) begin
            op_kind_q   <= op_kind;
            op_target_q <= op_target;
        end
    end

    always_comb begin
        state_next = state;
        pc_reset   = 1'b0;
        pc_mode    = PC_MODE_HOLD;
        pc_offset  = '0;
        fetch_req  = 1'b0;
        halted     = 1'b0;
`ifdef PC_CALL_STACK_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        case (state)
            CTRL_BOOT: begin
                pc_reset   = 1'b1;
                state_next = CTRL_FETCH;
            end
            CTRL_FETCH: begin
                fetch_req = 1'b1;
                if (mem_ready) begin
                    state_next = CTRL_EXEC;
                end
            end
            CTRL_EXEC: begin
                state_next = CTRL_FETCH;
                pc_mode    = PC_MODE_NORMAL;
                case (op_kind_q)
                    OP_JMP: begin
                        pc_mode   = PC_MODE_JUMP;
                        pc_offset = op_target_q;
                    end
                    OP_BR: begin
                        if (cond_flag) begin
                            pc_mode   = PC_MODE_ADD;
                            pc_offset = op_target_q;
                        end
                    end
                    OP_HALT: begin
                        pc_mode    = PC_MODE_HOLD;
                        state_next = CTRL_HALT;
                    end
`ifdef PC_CALL_STACK_EN
                    // A call on a full stack still jumps; only the push is dropped.
                    OP_CALL: begin
                        pc_mode   = PC_MODE_JUMP;
                        pc_offset = op_target_q;
                        push      = !stk_full;
                    end
                    OP_RET: begin
                        if (!stk_empty) begin
                            pop       = 1'b1;
                            pc_mode   = PC_MODE_JUMP;
                            pc_offset = stk_dout;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            CTRL_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_next = CTRL_RESUME;
                end
            end
            CTRL_RESUME: begin
                pc_mode    = PC_MODE_NORMAL;
                state_next = CTRL_FETCH;
            end
            default: begin
                state_next = CTRL_BOOT;
            end
        endcase
    end

`ifdef PC_CALL_STACK_EN
    assign ret_addr = pc_value + WIDTH'(1);

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stack_err <= 1'b0;
        end else if (state == CTRL_EXEC &&
                     ((op_kind_q == OP_CALL && stk_full) ||
                      (op_kind_q == OP_RET && stk_empty))) begin
            stack_err <= 1'b1;
        end
    end
`else
    logic pc_value_unused;
    assign pc_value_unused = ^pc_value;
    assign stack_err       = 1'b0;
`endif

endmodule
